// File: rtl/pipeline_skid_fifo_pkg.sv
// Shared helpers for the elastic output buffer.
package pipeline_skid_fifo_pkg;

    function automatic bit is_pow2_min2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/pipeline_skid_fifo.sv
// Elastic output buffer: small FIFO with a registered upstream ready that cuts
// the consumer-ready to pipeline-stall combinational path.
module pipeline_skid_fifo
    import pipeline_skid_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AFULL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       almost_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    if (!is_pow2_min2(DEPTH)) begin : g_bad_depth
        $error("pipeline_skid_fifo: DEPTH must be a power of two >= 2");
    end
    if ((AFULL < 1) || (AFULL > DEPTH)) begin : g_bad_afull
        $error("pipeline_skid_fifo: AFULL must lie in 1..DEPTH");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             in_ready_q;
    logic             almost_full_q;
    logic             push, pop;

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      level_d = level_q + 1'b1;
        else if (!push && pop) level_d = level_q - 1'b1;
    end

    // Ready and almost_full look at the post-edge level so a filling push
    // drops ready on the very next cycle and nothing is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            in_ready_q    <= 1'b1;
            almost_full_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            in_ready_q    <= (level_d != LVL_W'(DEPTH));
            almost_full_q <= (level_d >= LVL_W'(AFULL));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (level_q != '0);
    assign out_data    = mem_q[rd_ptr_q];
    assign level       = level_q;
    assign almost_full = almost_full_q;

endmodule

// File: tb/tb_pipeline_skid_fifo.sv
// Bench for pipeline_skid_fifo: directed scenarios plus a long random run,
// all checked against a queue-based model of the buffer.
module tb_pipeline_skid_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int AFULL = 3;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [LVL_W-1:0] level;
    logic             almost_full;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] mq[$];
    bit               m_ready;

    always #5 clk = ~clk;

    pipeline_skid_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL(AFULL)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .level(level), .almost_full(almost_full)
    );

    // Advance one clock; the model applies the handshake rules to the queue.
    task automatic step();
        bit push, pop;
        push = in_valid && m_ready;
        pop  = out_ready && (mq.size() != 0);
        @(posedge clk);
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(in_data);
        m_ready = (mq.size() != DEPTH);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        mq.delete(); m_ready = 1'b1;
        #1;
        checks++; if (level !== '0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got=%b exp=0", almost_full); end
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Mid-stream reset with three entries held.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'h100 + i;
            step();
        end
        in_valid = 1'b0;
        checks++; if (level !== LVL_W'(3)) begin errors++; $display("FAIL prereset_level got=%0d exp=3", level); end
        rst = 1'b1;
        mq.delete(); m_ready = 1'b1;
        #1;
        checks++; if (level !== '0) begin errors++; $display("FAIL midreset_level got=%0d exp=0", level); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready got=%b exp=1", in_ready); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL midreset_afull got=%b exp=0", almost_full); end
        #1 rst = 1'b0;
        in_valid = 1'b1; in_data = 32'hA5;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL postreset_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 32'hA5) begin errors++; $display("FAIL postreset_data got=%h exp=000000a5", out_data); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL postreset_empty got=%b exp=0", out_valid); end
        $display("test_reset done, errors=%0d", errors);
    endtask

    task automatic test_fill();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            in_data = i;
            step();
            checks++; if (level !== LVL_W'(i)) begin errors++; $display("FAIL fill_level i=%0d got=%0d exp=%0d", i, level, i); end
            checks++; if (almost_full !== (i >= AFULL)) begin errors++; $display("FAIL fill_afull i=%0d got=%b exp=%b", i, almost_full, i >= AFULL); end
            checks++; if (in_ready !== (i < DEPTH)) begin errors++; $display("FAIL fill_in_ready i=%0d got=%b exp=%b", i, in_ready, i < DEPTH); end
        end
        in_data = 5;
        step(); step();
        in_valid = 1'b0;
        checks++; if (level !== LVL_W'(DEPTH)) begin errors++; $display("FAIL fill_hold_level got=%0d exp=%0d", level, DEPTH); end
        checks++; if (out_data !== 32'd1) begin errors++; $display("FAIL fill_hold_head got=%0d exp=1", out_data); end
        $display("test_fill done, errors=%0d", errors);
    endtask

    task automatic test_drain();
        out_ready = 1'b1; in_valid = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            checks++; if (out_data !== WIDTH'(i)) begin errors++; $display("FAIL drain_data i=%0d got=%0d exp=%0d", i, out_data, i); end
            step();
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_in_ready i=%0d got=%b exp=1", i, in_ready); end
            checks++; if (level !== LVL_W'(DEPTH - i)) begin errors++; $display("FAIL drain_level i=%0d got=%0d exp=%0d", i, level, DEPTH - i); end
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
        $display("test_drain done, errors=%0d", errors);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 100; step();
        in_data = 101; step();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 102 + i;
            checks++; if (out_data !== WIDTH'(100 + i)) begin errors++; $display("FAIL b2b_data i=%0d got=%0d exp=%0d", i, out_data, 100 + i); end
            step();
            checks++; if (level !== LVL_W'(2)) begin errors++; $display("FAIL b2b_level i=%0d got=%0d exp=2", i, level); end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (out_data !== WIDTH'(120 + i)) begin errors++; $display("FAIL b2b_tail i=%0d got=%0d exp=%0d", i, out_data, 120 + i); end
            step();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
        $display("test_back_to_back done, errors=%0d", errors);
    endtask

    task automatic test_full_pop_push();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            in_data = 10 + i;
            step();
        end
        in_data = 14; out_ready = 1'b1;
        step();
        checks++; if (level !== LVL_W'(DEPTH - 1)) begin errors++; $display("FAIL fpp_level got=%0d exp=%0d", level, DEPTH - 1); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fpp_in_ready got=%b exp=1", in_ready); end
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        checks++; if (level !== LVL_W'(DEPTH)) begin errors++; $display("FAIL fpp_refill got=%0d exp=%0d", level, DEPTH); end
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (out_data !== WIDTH'(11 + i)) begin errors++; $display("FAIL fpp_data i=%0d got=%0d exp=%0d", i, out_data, 11 + i); end
            step();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty got=%b exp=0", out_valid); end
        $display("test_full_pop_push done, errors=%0d", errors);
    endtask

    task automatic test_random();
        bit holding;
        holding = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (!holding) begin
                in_valid = ($urandom_range(0, 99) < 60);
                in_data  = $urandom;
            end
            out_ready = ($urandom_range(0, 99) < 55);
            holding = in_valid && !m_ready;
            checks++; if (out_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, mq.size() != 0); end
            if (mq.size() != 0) begin
                checks++; if (out_data !== mq[0]) begin errors++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, out_data, mq[0]); end
            end
            step();
            checks++; if (level !== LVL_W'(mq.size())) begin errors++; $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, level, mq.size()); end
            checks++; if (in_ready !== m_ready) begin errors++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, in_ready, m_ready); end
            checks++; if (almost_full !== (mq.size() >= AFULL)) begin errors++; $display("FAIL rnd_afull c=%0d got=%b exp=%b", c, almost_full, mq.size() >= AFULL); end
            checks++; if (in_ready && (level == LVL_W'(DEPTH))) begin errors++; $display("FAIL rnd_ready_full c=%0d got=1 exp=0", c); end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        $display("test_random done, errors=%0d", errors);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_full_pop_push();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
